// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multiport register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks every register address once, one per cycle, while busy.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  output logic              idle,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state <= SWEEP;
            ptr   <= '0;
          end
        end
        SWEEP: begin
          // ptr wraps back to 0 as the last address is cleared
          ptr <= ptr + 1'b1;
          if (&ptr) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state == SWEEP);
  assign idle       = (state == IDLE);
  assign sweep_we   = busy;
  assign sweep_addr = ptr;

endmodule

// File: rtl/regfile_multiport.sv
// General-purpose register file: one write port, NUM_READ registered read ports,
// write-to-read bypass, read stall, optional hardwired r0 and sequenced bulk clear.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [NUM_READ*ADDR_W-1:0] ra,
  output logic [NUM_READ*DATA_W-1:0] rd,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic                       clear,
  output logic                       busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              idle;
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              we_eff;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .busy       (busy),
    .idle       (idle),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  assign we_eff = we & idle & ~((ZERO_REG != 0) & (wa == '0));

  // A write accepted in the same cycle CLEAR is sampled lands first and is swept later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (sweep_we) begin
      regs[sweep_addr] <= '0;
    end else if (we_eff) begin
      regs[wa] <= wd;
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = ra[g*ADDR_W +: ADDR_W];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        data <= '0;
      end else if (!stall) begin
        if (busy)                                data <= '0;
        else if ((ZERO_REG != 0) && addr == '0)  data <= '0;
        else if (we_eff && wa == addr)           data <= wd;
        else                                     data <= regs[addr];
      end
    end

    assign rd[g*DATA_W +: DATA_W] = data;
  end

endmodule
